// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with post-reset clear sweep and a small
// memory-mapped I/O window (LED, cycle counter, sticky error counter).
module data_mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_tipo_instr,
    input  logic        memwrite_tipo_instr,
    input  logic [31:0] memdirection_tipo_instr,
    input  logic [31:0] memaluout_tipo_instr,
    output logic [31:0] MEM_memout,
    output logic        busy,
    output logic [7:0]  led_out,
    output logic        err_flag
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        led_q, led_d;
    logic [31:0]       cyc_q;
    logic [31:0]       err_q, err_d;
    logic              flag_q, flag_d;

    logic [31:0]       mem [2**ADDR_W];

    logic              ready;
    logic              rd, wr;
    logic [31:0]       addr, wdata;
    logic [ADDR_W-1:0] widx;
    logic              is_io, misal, ram_oor, io_oor, bad;
    logic [1:0]        io_sel;
    logic              ok_rd, ok_wr, err_ev;
    logic [31:0]       rdata;

    assign ready   = (state_q == S_READY);
    assign rd      = memread_tipo_instr;
    assign wr      = memwrite_tipo_instr;
    assign addr    = memdirection_tipo_instr;
    assign wdata   = memaluout_tipo_instr;

    assign widx    = addr[ADDR_W+1:2];
    assign is_io   = addr[31];
    assign io_sel  = addr[3:2];
    assign misal   = |addr[1:0];
    assign ram_oor = |addr[30:ADDR_W+2];
    assign io_oor  = |addr[30:4];
    assign bad     = misal | (is_io ? (io_oor | (io_sel == 2'd3)) : ram_oor);

    assign ok_rd   = ready & rd & ~bad;
    assign ok_wr   = ready & wr & ~bad;
    assign err_ev  = ready & (rd | wr) & bad;

    // Read path is combinational so WB can latch it at the same edge.
    always_comb begin
        rdata = '0;
        if (is_io) begin
            case (io_sel)
                2'd0:    rdata = {24'h0, led_q};
                2'd1:    rdata = cyc_q;
                2'd2:    rdata = err_q;
                default: rdata = '0;
            endcase
        end else begin
            rdata = mem[widx];
        end
    end

    assign MEM_memout = ok_rd ? rdata : '0;
    assign busy       = ~ready;
    assign led_out    = led_q;
    assign err_flag   = flag_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        led_d   = led_q;
        err_d   = err_q;
        flag_d  = flag_q;
        case (state_q)
            S_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == {ADDR_W{1'b1}}) begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_READY;
        endcase
        if (ok_wr && is_io && io_sel == 2'd0) begin
            led_d = wdata[7:0];
        end
        if (ok_wr && is_io && io_sel == 2'd2) begin
            err_d  = '0;
            flag_d = 1'b0;
        end else if (err_ev) begin
            flag_d = 1'b1;
            if (err_q != 32'hFFFF_FFFF) begin
                err_d = err_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
            led_q   <= '0;
            cyc_q   <= '0;
            err_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            cyc_q   <= cyc_q + 32'd1;
            err_q   <= err_d;
            flag_q  <= flag_d;
        end
    end

    // RAM has no reset; the clear sweep owns it until READY.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[idx_q] <= CLEAR_VAL;
        end else if (ok_wr && !is_io) begin
            mem[widx] <= wdata;
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the scalar/vector pipeline's data-memory request interface.
- Serves read/write requests from the pipeline's MEM stage:
  - memread_tipo_instr / memwrite_tipo_instr strobes.
  - memdirection_tipo_instr address.
  - memaluout_tipo_instr write data.
  - Returns MEM_memout.
- Contains:
  - word RAM;
  - post-reset clear state machine;
  - small memory-mapped I/O window (LED register, cycle counter, error counter).
- Sits at top level beside mips_pipeline; its busy output holds the core in reset until RAM clear completes.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- CLEAR_VAL, 32'h0000_0000, value written to every RAM word during post-reset clear.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- memread_tipo_instr  input  1  read strobe, one request per cycle
- memwrite_tipo_instr  input  1  write strobe, one request per cycle
- memdirection_tipo_instr  input  32  byte address of request
- memaluout_tipo_instr  input  32  write data
- MEM_memout  output  32  read data (combinational from current-cycle address)
- busy  output  1  high while clear FSM runs; core must be held in reset
- led_out  output  8  LED I/O register
- err_flag  output  1  sticky: any error since last clear of error counter

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM -> CLEAR, clear index=0, busy=1.
  - led_out=0, cycle counter=0, error counter=0, err_flag=0.
  - MEM_memout=0.
  - RAM contents not reset directly.
- FSM states CLEAR and READY:
  - CLEAR: each cycle writes CLEAR_VAL to RAM[index], index+1. After writing index 2**ADDR_W-1, next state READY, busy=0. Clear takes exactly 2**ADDR_W cycles after reset release.
  - CLEAR: all requests ignored, no counters change except cycle counter, MEM_memout=0.
  - READY: stays until reset.
- Address decode in READY:
  - addr[31]=0: RAM region, word index = addr[ADDR_W+1:2].
  - Any of addr[30:ADDR_W+2] nonzero: out-of-range.
  - addr[1:0]!=0: misaligned.
  - addr[31]=1: I/O region, decoded on addr[3:2] with addr[30:4]=0 required, else out-of-range:
    - 0: LED — R/W, low 8 bits; reads zero-extended.
    - 1: cycle counter — RO; writes ignored, no error.
    - 2: error counter — read returns count; any write clears it to 0 and clears err_flag.
    - 3: unmapped — error.
- Reads:
  - MEM_memout is combinational from RAM/I/O for the current address when memread_tipo_instr=1 in READY, so the pipeline latches it into WB at the same edge.
  - Otherwise MEM_memout=0.
  - Errored reads return 0.
- Writes: RAM or I/O updated at the rising edge where memwrite_tipo_instr=1 in READY; errored writes have no effect.
- Simultaneous read and write, same cycle:
  - Write takes effect at the edge.
  - MEM_memout shows the pre-write value (no bypass).
- Errors (misaligned, out-of-range, unmapped), counted once per cycle only if a strobe is active:
  - Error counter +1, saturating at 32'hFFFF_FFFF.
  - err_flag set.
  - A write clear to the error counter in the same cycle as an error elsewhere is impossible (one request/cycle).
- Cycle counter:
  - Increments every cycle after reset release, including CLEAR.
  - Wraps modulo 2**32.
- Reset asserted mid-clear or mid-operation: immediate return to CLEAR; clear restarts from index 0.

Test Plan:
- Reset release with ADDR_W=4 -> busy=1 for exactly 16 cycles, then 0. Every word reads CLEAR_VAL; writes issued during CLEAR leave RAM unchanged.
- Write 0x12345678 to 0x0000_0008, then read 0x0000_0008 -> MEM_memout=0x12345678 in the read cycle. Read of 0x0000_000C -> CLEAR_VAL.
- Same cycle: read+write 0x0000_0010 with data 0xAAAA5555 (old 0) -> MEM_memout=0 that cycle; next-cycle read -> 0xAAAA5555.
- Bad requests:
  - Read 0x0000_0002 -> MEM_memout=0, error count 1, err_flag=1.
  - Write 0x0000_1000 (ADDR_W=4) -> error count 2, RAM unchanged.
  - Write any value to 0x8000_0008 -> count 0, err_flag=0.
- I/O:
  - Write 0x0000_01A5 to 0x8000_0000 -> led_out=0xA5; read 0x8000_0000 -> 0x0000_00A5.
  - Write to 0x8000_0004 -> no change, no error.
- Assert reset mid-clear (index 7), release -> busy high for a full 2**ADDR_W cycles again. led_out=0, counters=0.
